// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 Pmod keypad responder (column strobe in, row sense out); macro KEYPAD_EMU_BOUNCE_EN adds contact chatter
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 2_000_000,
    parameter int GAP_CYCLES    = 2_000_000,
    parameter int BOUNCE_CYCLES = 200_000,
    parameter int BOUNCE_PERIOD = 10_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       busy,
    output logic       done
);
    localparam int MX0 = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MX  = MX0 > BOUNCE_CYCLES ? MX0 : BOUNCE_CYCLES;
    localparam int CW  = $clog2(MX + 1);
    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     code_q, code_d, rows_q, rows_d;
    logic [1:0]     key_row, key_col;
    logic           contact;
    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_PERIOD < 1) begin : g_bad_param
        $error("keypad_emulator: HOLD_CYCLES, GAP_CYCLES and BOUNCE_PERIOD must be >= 1");
    end
    // key position of the latched code on the physical 4x4 matrix
    always_comb begin
        case (code_q)
            4'h1: {key_row, key_col} = 4'b00_00;
            4'h2: {key_row, key_col} = 4'b00_01;
            4'h3: {key_row, key_col} = 4'b00_10;
            4'hA: {key_row, key_col} = 4'b00_11;
            4'h4: {key_row, key_col} = 4'b01_00;
            4'h5: {key_row, key_col} = 4'b01_01;
            4'h6: {key_row, key_col} = 4'b01_10;
            4'hB: {key_row, key_col} = 4'b01_11;
            4'h7: {key_row, key_col} = 4'b10_00;
            4'h8: {key_row, key_col} = 4'b10_01;
            4'h9: {key_row, key_col} = 4'b10_10;
            4'hC: {key_row, key_col} = 4'b10_11;
            4'h0: {key_row, key_col} = 4'b11_00;
            4'hF: {key_row, key_col} = 4'b11_01;
            4'hE: {key_row, key_col} = 4'b11_10;
            default: {key_row, key_col} = 4'b11_11;
        endcase
    end
    // press/gap sequencing, handshake outputs and next row drive
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        key_ready = state_q == IDLE;
        busy      = state_q != IDLE;
        done      = 1'b0;
        case (state_q)
            IDLE: if (key_valid) begin
                state_d = PRESS;
                cnt_d   = CW'(HOLD_CYCLES - 1);
                code_d  = key_code;
            end
            PRESS: if (cnt_q == '0) begin
                state_d = GAP;
                cnt_d   = CW'(GAP_CYCLES - 1);
            end else cnt_d = cnt_q - 1'b1;
            GAP: if (cnt_q == '0) begin
                state_d = IDLE;
                done    = 1'b1;
            end else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
        rows_d = 4'hF;
        if (state_q == PRESS && contact && !cols[key_col]) rows_d[key_row] = 1'b0;
    end
    // state, counter, latched key and registered row drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            rows_q  <= 4'hF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            rows_q  <= rows_d;
        end
    end
    assign rows = rows_q;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int WIN = BOUNCE_CYCLES < HOLD_CYCLES ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int PW  = $clog2(BOUNCE_PERIOD + 1);
    logic [CW-1:0] el_q;
    logic [PW-1:0] ph_q;
    logic          open_q;
    // chatter mask: elapsed PRESS cycles and toggle phase, cleared while idle so each press starts closed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            el_q   <= '0;
            ph_q   <= '0;
            open_q <= 1'b0;
        end else if (state_q == IDLE) begin
            el_q   <= '0;
            ph_q   <= '0;
            open_q <= 1'b0;
        end else if (state_q == PRESS) begin
            el_q   <= el_q + 1'b1;
            ph_q   <= (ph_q == PW'(BOUNCE_PERIOD - 1)) ? '0 : ph_q + 1'b1;
            if (ph_q == PW'(BOUNCE_PERIOD - 1)) open_q <= ~open_q;
        end
    end
    assign contact = (el_q >= CW'(WIN)) || !open_q;
`else
    assign contact = 1'b1;
`endif
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: table vectors, hand sequences and random stimulus against a cycle-count reference model
module tb_keypad_emulator;
    localparam int H = 8, G = 4, BC = 4, BP = 1;
    logic       clk = 1'b0, rst = 1'b1;
    logic [3:0] cols = 4'hF, key_code = 4'h0, rows;
    logic       key_valid = 1'b0, key_ready, busy, done;
    int         n_cmp = 0, n_bad = 0;
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bit         m_act;
    int         m_t;
    logic [3:0] m_key, m_rows;
    typedef struct {
        logic [3:0] c;
        logic       v;
        logic [3:0] k;
        logic [3:0] rows;
        logic       rdy, bsy, dn;
    } vec_t;
    vec_t tbl [17];

    keypad_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_CYCLES(BC), .BOUNCE_PERIOD(BP)) dut (
        .clk(clk), .rst(rst), .cols(cols), .rows(rows), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_rows_next(input logic [3:0] c);
        int idx;
        bit contact;
        idx = 0;
        contact = 1'b1;
        for (int i = 0; i < 16; i++) if (keymap[i] == m_key) idx = i;
`ifdef KEYPAD_EMU_BOUNCE_EN
        if (m_t < ((BC < H) ? BC : H)) contact = ((m_t / BP) % 2) == 0;
`endif
        return (m_act && m_t < H && contact && c[idx % 4] == 1'b0) ? ~(4'b0001 << (idx / 4)) : 4'hF;
    endfunction

    task automatic model_reset();
        m_act = 1'b0;
        m_t = 0;
        m_key = 4'h0;
        m_rows = 4'hF;
    endtask

    task automatic cyc(input logic [3:0] c, input logic v, input logic [3:0] k);
        cols = c;
        key_valid = v;
        key_code = k;
        @(posedge clk);
        m_rows = model_rows_next(c);
        if (m_act) begin
            m_t++;
            if (m_t == H + G) m_act = 1'b0;
        end else if (v) begin
            m_act = 1'b1;
            m_t = 0;
            m_key = k;
        end
        @(negedge clk);
    endtask

    task automatic check_model();
        chk("rows", rows, m_rows);
        chk("key_ready", key_ready, !m_act);
        chk("busy", busy, m_act);
        chk("done", done, m_act && m_t == H + G - 1);
        chk("rows_onehot", $countones(~rows) <= 1, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && busy; i++) begin
            cyc(cols, 1'b0, 4'h0);
            check_model();
        end
        chk("drain_timeout", busy, 0);
    endtask

    task automatic run_rot();
        int lo, dn;
        lo = 0;
        dn = 0;
        cyc(4'b1110, 1'b1, 4'h5);
        check_model();
        lo += !key_ready;
        dn += done;
        for (int i = 0; i < 15; i++) begin
            cyc(rot[(i + 1) % 4], 1'b0, 4'h5);
            check_model();
            lo += !key_ready;
            dn += done;
        end
        chk("rot_ready_low_cycles", lo, 12);
        chk("rot_done_pulses", dn, 1);
    endtask

    initial begin
        int hi;
        logic [3:0] c;
        tbl[0] = '{4'b0111, 1'b1, 4'hD, 4'hF, 1'b0, 1'b1, 1'b0};
        for (int i = 1; i <= 8; i++) tbl[i] = '{4'b0111, 1'b0, 4'hD, 4'b0111, 1'b0, 1'b1, 1'b0};
`ifdef KEYPAD_EMU_BOUNCE_EN
        tbl[2].rows = 4'hF;
        tbl[4].rows = 4'hF;
`endif
        tbl[9]  = '{4'b0111, 1'b0, 4'hD, 4'hF, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{4'b0111, 1'b0, 4'hD, 4'hF, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{4'b0111, 1'b0, 4'hD, 4'hF, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{4'b0111, 1'b0, 4'hD, 4'hF, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{4'b0111, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0};
        for (int i = 14; i <= 16; i++) tbl[i] = '{4'b0111, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0};
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_model();
        rst = 1'b0;
        run_rot();
        drain();
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].c, tbl[i].v, tbl[i].k);
            chk($sformatf("tbl%0d_rows", i), rows, tbl[i].rows);
            chk($sformatf("tbl%0d_ready", i), key_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
        end
        drain();
        hi = 0;
        cyc(4'b1101, 1'b1, 4'h5);
        check_model();
        for (int i = 0; i < 20; i++) begin
            cyc(4'b1101, 1'b1, (i < 6) ? 4'h5 : 4'h9);
            check_model();
            hi += key_ready;
        end
        chk("hold_valid_ready_cycles", hi, 1);
        drain();
        cyc(4'b1101, 1'b1, 4'h5);
        for (int i = 0; i < 3; i++) cyc(4'b1101, 1'b0, 4'h5);
        check_model();
        chk("pre_reset_rows", rows, 4'b1101);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rows", rows, 4'hF);
        chk("async_rst_ready", key_ready, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        model_reset();
        @(negedge clk);
        check_model();
        rst = 1'b0;
        run_rot();
        drain();
`ifdef KEYPAD_EMU_BOUNCE_EN
        begin
            logic [7:0] exp_b;
            exp_b = 8'b0000_1010;
            cyc(4'b1110, 1'b1, 4'h1);
            check_model();
            for (int i = 0; i < 8; i++) begin
                cyc(4'b1110, 1'b0, 4'h1);
                check_model();
                chk($sformatf("bounce_row0_%0d", i), rows[0], exp_b[i]);
            end
            drain();
        end
`endif
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : rot[$urandom_range(0, 3)];
            cyc(c, $urandom_range(0, 3) == 0, 4'($urandom));
            check_model();
        end
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
